// File: rtl/alm_pkg.sv
// Shared ALM datapath constants and the set-one log-adder reference arithmetic.
package alm_pkg;

   localparam int ALM_SUM_W = 20;
   localparam int ALM_M_DEF = 11;

   function automatic int alm_opw(input int m);
      return ALM_SUM_W - m;
   endfunction

   // Operands arrive zero-extended in the low (20-m) bits; upper bits are ignored.
   function automatic logic [ALM_SUM_W-1:0] soa_model(input logic [ALM_SUM_W-1:0] a,
                                                      input logic [ALM_SUM_W-1:0] b,
                                                      input int m);
      logic [ALM_SUM_W-1:0] mask;
      logic [ALM_SUM_W-1:0] av;
      logic [ALM_SUM_W-1:0] bv;
      logic [ALM_SUM_W-1:0] hi;
      mask = (ALM_SUM_W'(1) << (ALM_SUM_W - m)) - ALM_SUM_W'(1);
      av   = a & mask;
      bv   = b & mask;
      hi   = (av >> 1) + (bv >> 1) + {{(ALM_SUM_W-1){1'b0}}, av[0] & bv[0]};
      return (hi << m) | ((ALM_SUM_W'(1) << m) - ALM_SUM_W'(1));
   endfunction

endpackage

// File: rtl/alm_rr_arb.sv
// Round-robin pick of the first request at or after the pointer; combinational grant,
// pointer advances past the winner only on a grant. Grants are suppressed while en_i is low.
module alm_rr_arb #(
   parameter int N_REQ = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDW-1:0]   gnt_idx_o,
   output logic             gnt_vld_o
);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW:0]   cand_w;
   logic [IDW-1:0] cand;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      cand_w    = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         // Wrap at N_REQ rather than 2**IDW so non-power-of-two counts stay in range.
         cand_w = {1'b0, ptr_q} + (IDW+1)'(i);
         if (cand_w >= (IDW+1)'(N_REQ)) begin
            cand_w = cand_w - (IDW+1)'(N_REQ);
         end
         cand = cand_w[IDW-1:0];
         if (en_i && !gnt_vld_o && req_i[cand]) begin
            gnt_vld_o   = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_idx_o   = cand;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld_o) begin
         ptr_d = (gnt_idx_o == IDW'(N_REQ-1)) ? '0 : gnt_idx_o + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alm_soa_sched.sv
// Shares one set-one log adder among N_REQ requesters: grant -> operand reg -> result reg, 2-cycle
// latency, 1 result/cycle; a stalled result holds both stages. ALM_SOA_STATS_EN adds stat_ops/stat_stall.
module alm_soa_sched
   import alm_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int M     = ALM_M_DEF,
   parameter  int IDW   = $clog2(N_REQ),
   localparam int W     = alm_opw(M)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*W-1:0]   req_a,
   input  logic [N_REQ*W-1:0]   req_b,
   output logic [W-1:0]         add_a,
   output logic [W-1:0]         add_b,
   input  logic [ALM_SUM_W-1:0] add_sum,
   output logic                 res_valid,
   input  logic                 res_ready,
`ifdef ALM_SOA_STATS_EN
   output logic [15:0]          stat_ops,
   output logic [15:0]          stat_stall,
`endif
   output logic [ALM_SUM_W-1:0] res_sumlog,
   output logic [IDW-1:0]       res_id
);

   logic                 s1_valid_q, s1_valid_d;
   logic [IDW-1:0]       s1_id_q, s1_id_d;
   logic [W-1:0]         add_a_q, add_a_d;
   logic [W-1:0]         add_b_q, add_b_d;
   logic                 res_valid_q, res_valid_d;
   logic [ALM_SUM_W-1:0] res_sum_q, res_sum_d;
   logic [IDW-1:0]       res_id_q, res_id_d;

   logic           s2_free, s1_free;
   logic           gnt_vld;
   logic [IDW-1:0] gnt_idx;
   logic [W-1:0]   sel_a, sel_b;

   assign s2_free = !res_valid_q || res_ready;
   assign s1_free = !s1_valid_q || s2_free;

   // Grant implies the winner is valid, so a grant is always a transfer.
   alm_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (s1_free),
      .req_i     (req_valid),
      .gnt_o     (req_ready),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            sel_a = req_a[i*W +: W];
            sel_b = req_b[i*W +: W];
         end
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_id_d     = s1_id_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_id_d    = res_id_q;

      if (gnt_vld) begin
         s1_valid_d = 1'b1;
         s1_id_d    = gnt_idx;
         add_a_d    = sel_a;
         add_b_d    = sel_b;
      end else if (s2_free) begin
         s1_valid_d = 1'b0;
      end

      if (s1_valid_q && s2_free) begin
         res_valid_d = 1'b1;
         res_sum_d   = add_sum;
         res_id_d    = s1_id_q;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_id_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_id_q    <= res_id_d;
      end
   end

   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign res_valid  = res_valid_q;
   assign res_sumlog = res_sum_q;
   assign res_id     = res_id_q;

`ifdef ALM_SOA_STATS_EN
   logic [15:0] stat_ops_q, stat_ops_d;
   logic [15:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_ops_d   = stat_ops_q;
      stat_stall_d = stat_stall_q;
      if (res_valid_q && res_ready && stat_ops_q != 16'hFFFF) begin
         stat_ops_d = stat_ops_q + 16'd1;
      end
      if (res_valid_q && !res_ready && stat_stall_q != 16'hFFFF) begin
         stat_stall_d = stat_stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_ops_q   <= stat_ops_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_ops   = stat_ops_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alm_soa_sched.sv
// Randomised plus directed bench for alm_soa_sched; provides the shared adder and a
// round-robin / two-slot-occupancy reference with a result scoreboard.
module tb_alm_soa_sched;

   localparam int N   = 4;
   localparam int M   = 11;
   localparam int W   = 9;
   localparam int IDW = 2;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [W-1:0]     add_a;
   logic [W-1:0]     add_b;
   logic [19:0]      add_sum;
   logic             res_valid;
   logic             res_ready;
   logic [19:0]      res_sumlog;
   logic [IDW-1:0]   res_id;
`ifdef ALM_SOA_STATS_EN
   logic [15:0]      stat_ops;
   logic [15:0]      stat_stall;
`endif

   typedef struct { int id; logic [19:0] sum; } exp_t;
   typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;

   exp_t       sb[$];
   op_t        pend[N][$];
   int         mptr;
   logic [N-1:0] xfer_flag;
   int         n_cmp;
   int         n_err;
   int         dut_xfers;

   alm_soa_sched #(.N_REQ(N), .M(M)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_sum    (add_sum),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
`ifdef ALM_SOA_STATS_EN
      .stat_ops   (stat_ops),
      .stat_stall (stat_stall),
`endif
      .res_sumlog (res_sumlog),
      .res_id     (res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Set-one log add: upper field = a/2 + b/2 + (both LSBs set), low M bits forced to one.
   function automatic logic [19:0] exp_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      int hi;
      hi = (int'(a) / 2) + (int'(b) / 2) + ((a[0] && b[0]) ? 1 : 0);
      return 20'(hi * (2 ** M) + (2 ** M) - 1);
   endfunction

   always_comb add_sum = exp_sum(add_a, add_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      op_t o;
      o.a = a;
      o.b = b;
      pend[i].push_back(o);
   endtask

   function automatic bit pend_any();
      for (int i = 0; i < N; i++) if (pend[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_drain(input int max_cyc);
      int t;
      t = 0;
      while ((sb.size() != 0 || pend_any()) && t < max_cyc) begin
         @(posedge clk); #3;
         t++;
      end
      n_cmp++;
      if (sb.size() != 0 || pend_any()) begin
         n_err++;
         $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", sb.size(), t);
      end
   endtask

   task automatic wait_res(input int max_cyc);
      int t;
      t = 0;
      do begin
         @(negedge clk); #2;
         t++;
      end while (!res_valid && t < max_cyc);
      if (!res_valid) check("res_valid_timeout", 32'(res_valid), 1);
   endtask

   // Requesters: each presents the head of its pending list until it is accepted.
   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      forever begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (xfer_flag[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            req_valid[i] = (pend[i].size() > 0);
            if (pend[i].size() > 0) begin
               req_a[i*W +: W] = pend[i][0].a;
               req_b[i*W +: W] = pend[i][0].b;
            end
         end
      end
   end

   // Reference: accept unless two results are already in flight and downstream blocks;
   // the accepted requester is the first valid one at or after the rotating pointer.
   initial begin : grant_model
      int           g;
      int           idx;
      logic         blocked;
      logic [N-1:0] exp_rdy;
      exp_t         e;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) begin
            mptr = 0;
            sb.delete();
            xfer_flag = '0;
         end else begin
            blocked = (sb.size() >= 2) && !res_ready;
            g = -1;
            if (!blocked) begin
               for (int k = 0; k < N; k++) begin
                  idx = (mptr + k) % N;
                  if (g < 0 && req_valid[idx]) g = idx;
               end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            dut_xfers += $countones(req_valid & req_ready);
            xfer_flag = exp_rdy;
            if (g >= 0) begin
               e.id  = g;
               e.sum = exp_sum(req_a[g*W +: W], req_b[g*W +: W]);
               sb.push_back(e);
               mptr = (g + 1) % N;
            end
         end
      end
   end

   // Monitor: a presented result must match the oldest outstanding one, every cycle it is held.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL res_unexpected: got id %0d sum %0h, required no result", res_id, res_sumlog);
            end else begin
               check("res_id", 32'(res_id), sb[0].id);
               check("res_sumlog", 32'(res_sumlog), 32'(sb[0].sum));
               if (res_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #1500000;
      n_err++;
      $display("FAIL watchdog: time limit reached, required bench completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int got[$];
      int first_c;
      int last_c;
      int base;
      n_cmp = 0;
      n_err = 0;
      dut_xfers = 0;
      mptr = 0;
      xfer_flag = '0;
      res_ready = 1'b1;
      rst_n = 1'b0;

      repeat (3) @(posedge clk);
      #3;
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_add_a", 32'(add_a), 0);
      check("rst_add_b", 32'(add_b), 0);
      check("rst_res_sumlog", 32'(res_sumlog), 0);
      check("rst_res_id", 32'(res_id), 0);
      check("rst_req_ready", 32'(req_ready), 0);
`ifdef ALM_SOA_STATS_EN
      check("rst_stat_ops", 32'(stat_ops), 0);
      check("rst_stat_stall", 32'(stat_stall), 0);
`endif
      @(posedge clk); #3;
      rst_n = 1'b1;

      // Fairness: all four requesters continuously valid for 8 transfers.
      @(posedge clk); #3;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push_op(i, W'($urandom), W'($urandom));
      first_c = -1;
      last_c  = -1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk); #2;
         if (res_valid && res_ready) begin
            got.push_back(int'(res_id));
            if (first_c < 0) first_c = c;
            last_c = c;
         end
      end
      check("fair_count", got.size(), 8);
      for (int k = 0; k < 8; k++) if (k < got.size()) check("fair_id", got[k], k % 4);
      check("fair_no_bubble", last_c - first_c + 1, 8);
      wait_drain(50);

      // Single request from requester 0: result two cycles after the grant.
      @(posedge clk); #3;
      push_op(0, 9'h001, 9'h001);
      begin
         int t;
         t = 0;
         do begin @(negedge clk); #2; t++; end while (!xfer_flag[0] && t < 20);
         check("single_grant", 32'(xfer_flag[0]), 1);
      end
      @(negedge clk); #2;
      check("lat_k1_res_valid", 32'(res_valid), 0);
      @(negedge clk); #2;
      check("lat_k2_res_valid", 32'(res_valid), 1);
      check("single_sumlog", 32'(res_sumlog), 32'h00FFF);
      check("single_id", 32'(res_id), 0);
      wait_drain(50);

      // Upper-field overflow boundary.
      @(posedge clk); #3;
      push_op(2, 9'h1FF, 9'h1FF);
      wait_res(20);
      check("ovf_sumlog", 32'(res_sumlog), 32'hFFFFF);
      check("ovf_id", 32'(res_id), 2);
      wait_drain(50);

      // Backpressure: three requests against a blocked output.
      @(posedge clk); #3;
      res_ready = 1'b0;
      base = dut_xfers;
      push_op(1, 9'h0A5, 9'h13C);
      push_op(2, 9'h07E, 9'h101);
      push_op(3, 9'h1F0, 9'h00F);
      repeat (6) @(posedge clk);
      #3;
      check("bp_accepted", dut_xfers - base, 2);
      @(negedge clk); #2;
      check("bp_ready_zero", 32'(req_ready), 0);
      @(posedge clk); #3;
      res_ready = 1'b1;
      wait_drain(50);
      check("bp_total_accepted", dut_xfers - base, 3);

      // Reset with both stages full: everything in flight is dropped.
      @(posedge clk); #3;
      res_ready = 1'b0;
      push_op(1, 9'h155, 9'h0AA);
      push_op(2, 9'h1AB, 9'h0CD);
      push_op(3, 9'h123, 9'h045);
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_res_valid", 32'(res_valid), 0);
      check("rst_mid_add_a", 32'(add_a), 0);
      check("rst_mid_res_sumlog", 32'(res_sumlog), 0);
      for (int i = 0; i < N; i++) pend[i].delete();
      for (int i = 0; i < N; i++) push_op(i, W'($urandom), W'($urandom));
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk); #2;
      check("rst_first_grant", 32'(req_ready), 32'h1);
      wait_drain(50);

      // Random traffic with random downstream stalls.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #3;
         res_ready = ($urandom_range(0, 99) < 70);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 99) < 25 && pend[i].size() < 3)
               push_op(i, W'($urandom), W'($urandom));
      end
      @(posedge clk); #3;
      res_ready = 1'b1;
      wait_drain(200);

`ifdef ALM_SOA_STATS_EN
      @(posedge clk); #3;
      rst_n = 1'b0;
      res_ready = 1'b0;
      @(posedge clk); #3;
      check("stat_rst_ops", 32'(stat_ops), 0);
      check("stat_rst_stall", 32'(stat_stall), 0);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) push_op(0, W'($urandom), W'($urandom));
      wait_res(20);
      repeat (3) @(posedge clk);
      #3;
      res_ready = 1'b1;
      wait_drain(100);
      check("stat_ops_10", 32'(stat_ops), 10);
      check("stat_stall_3", 32'(stat_stall), 3);
      @(posedge clk); #3;
      res_ready = 1'b0;
      push_op(1, W'($urandom), W'($urandom));
      repeat (65540) @(posedge clk);
      #3;
      check("stat_stall_sat", 32'(stat_stall), 32'hFFFF);
      res_ready = 1'b1;
      wait_drain(50);
      check("stat_stall_hold", 32'(stat_stall), 32'hFFFF);
      check("stat_ops_11", 32'(stat_ops), 11);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
